reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 101 ++++++++++
 tb/tb_reg_write_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that funnels NREQ requesters onto one shared register write port.
// Each grant runs IDLE -> WRITE (reg_en pulse) -> ACK (ack pulse) -> IDLE.
module reg_write_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    localparam int GIDW = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       ack,
    output logic                  reg_en,
    output logic [WIDTH-1:0]      reg_data,
    output logic [GIDW-1:0]       grant_id,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t            state_reg;
    logic [GIDW-1:0]   last_grant_reg;
    logic [GIDW-1:0]   win_next;
    logic              found_next;
    logic [WIDTH-1:0]  slice_data [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign slice_data[gi] = wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Search starts just after the last winner and wraps; first asserted req wins.
    always_comb begin
        logic [GIDW:0] cand;
        win_next   = '0;
        found_next = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_grant_reg} + (GIDW+1)'(k);
            if (cand >= (GIDW+1)'(NREQ))
                cand = cand - (GIDW+1)'(NREQ);
            if (!found_next && req[cand[GIDW-1:0]]) begin
                found_next = 1'b1;
                win_next   = cand[GIDW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            reg_en         <= 1'b0;
            ack            <= '0;
            busy           <= 1'b0;
            reg_data       <= '0;
            grant_id       <= '0;
            last_grant_reg <= GIDW'(NREQ-1);
        end else begin
            case (state_reg)
                IDLE: begin
                    ack <= '0;
                    if (found_next) begin
                        state_reg <= WRITE;
                        grant_id  <= win_next;
                        reg_data  <= slice_data[win_next];
                        reg_en    <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        reg_en <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                WRITE: begin
                    state_reg      <= ACK;
                    reg_en         <= 1'b0;
                    ack            <= NREQ'(1) << grant_id;
                    last_grant_reg <= grant_id;
                    busy           <= 1'b1;
                end
                ACK: begin
                    state_reg <= IDLE;
                    ack       <= '0;
                    reg_en    <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    reg_en    <= 1'b0;
                    ack       <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a transaction-level reference model.
module tb_reg_write_arbiter;

    localparam int WIDTH = 16;
    localparam int NREQ  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       ack;
    logic                  reg_en;
    logic [WIDTH-1:0]      reg_data;
    logic [1:0]            grant_id;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    reg_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .ack(ack),
        .reg_en(reg_en), .reg_data(reg_data), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [63:0] wdata;
        logic        en;
        logic [3:0]  ack;
        logic [15:0] data;
        logic [1:0]  gid;
        logic        busy;
    } vec_t;

    vec_t vecs [13];

    // Reference model: transaction-level view (phase since grant, last winner).
    int          m_phase;
    int          m_last;
    int          m_gid;
    logic [15:0] m_data;
    logic        m_en;
    logic [3:0]  m_ack;
    logic        m_busy;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic en, input logic [3:0] a,
                           input logic [15:0] d, input logic [1:0] g, input logic b);
        chk({tag, "_reg_en"},   64'(reg_en),   64'(en));
        chk({tag, "_ack"},      64'(ack),      64'(a));
        chk({tag, "_reg_data"}, 64'(reg_data), 64'(d));
        chk({tag, "_grant_id"}, 64'(grant_id), 64'(g));
        chk({tag, "_busy"},     64'(busy),     64'(b));
    endtask

    function automatic void model_reset();
        m_phase = 0; m_last = NREQ-1; m_gid = 0;
        m_data = '0; m_en = 0; m_ack = '0; m_busy = 0;
    endfunction

    function automatic void model_edge(input logic [3:0] r, input logic [63:0] w);
        int win;
        if (m_phase == 0) begin
            m_ack = '0;
            win = -1;
            for (int k = 1; k <= NREQ; k++)
                if (win < 0 && r[(m_last + k) % NREQ]) win = (m_last + k) % NREQ;
            if (win >= 0) begin
                m_gid = win; m_data = w[win*16 +: 16];
                m_en = 1; m_busy = 1; m_phase = 1;
            end else begin
                m_en = 0; m_busy = 0;
            end
        end else if (m_phase == 1) begin
            m_en = 0; m_ack = 4'b1 << m_gid; m_last = m_gid; m_busy = 1; m_phase = 2;
        end else begin
            m_ack = '0; m_en = 0; m_busy = 0; m_phase = 0;
        end
    endfunction

    initial begin
        logic [63:0] w;
        w = 64'h3333_2B2B_1111_0C0C;
        vecs[0]  = '{4'b0001, 64'h0000_0000_0000_A5A5, 1'b1, 4'b0000, 16'hA5A5, 2'd0, 1'b1};
        vecs[1]  = '{4'b0001, 64'h0000_0000_0000_FFFF, 1'b0, 4'b0001, 16'hA5A5, 2'd0, 1'b1};
        vecs[2]  = '{4'b0000, 64'h0000_0000_0000_FFFF, 1'b0, 4'b0000, 16'hA5A5, 2'd0, 1'b0};
        vecs[3]  = '{4'b0000, 64'h0000_0000_0000_FFFF, 1'b0, 4'b0000, 16'hA5A5, 2'd0, 1'b0};
        vecs[4]  = '{4'b0100, w, 1'b1, 4'b0000, 16'h2B2B, 2'd2, 1'b1};
        vecs[5]  = '{4'b0100, w, 1'b0, 4'b0100, 16'h2B2B, 2'd2, 1'b1};
        vecs[6]  = '{4'b0000, w, 1'b0, 4'b0000, 16'h2B2B, 2'd2, 1'b0};
        vecs[7]  = '{4'b0101, w, 1'b1, 4'b0000, 16'h0C0C, 2'd0, 1'b1};
        vecs[8]  = '{4'b0101, w, 1'b0, 4'b0001, 16'h0C0C, 2'd0, 1'b1};
        vecs[9]  = '{4'b0100, w, 1'b0, 4'b0000, 16'h0C0C, 2'd0, 1'b0};
        vecs[10] = '{4'b0100, w, 1'b1, 4'b0000, 16'h2B2B, 2'd2, 1'b1};
        vecs[11] = '{4'b0100, w, 1'b0, 4'b0100, 16'h2B2B, 2'd2, 1'b1};
        vecs[12] = '{4'b0000, w, 1'b0, 4'b0000, 16'h2B2B, 2'd2, 1'b0};

        rst = 1'b1; req = '0; wdata = '0;
        step(); step();
        chk_all("reset", 1'b0, 4'b0000, 16'h0000, 2'd0, 1'b0);
        rst = 1'b0;

        // Directed table: basic write, data stability, wrap-around round robin.
        for (int i = 0; i < 13; i++) begin
            req = vecs[i].req; wdata = vecs[i].wdata;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].en, vecs[i].ack, vecs[i].data,
                    vecs[i].gid, vecs[i].busy);
        end

        // One-cycle request pulse still completes with a single ack.
        req = 4'b0010; wdata = 64'h0000_0000_1234_0000;
        step(); chk_all("pulse_grant", 1'b1, 4'b0000, 16'h1234, 2'd1, 1'b1);
        req = 4'b0000; wdata = 64'h0000_0000_DEAD_0000;
        step(); chk_all("pulse_ack", 1'b0, 4'b0010, 16'h1234, 2'd1, 1'b1);
        step(); chk_all("pulse_idle", 1'b0, 4'b0000, 16'h1234, 2'd1, 1'b0);
        step(); chk_all("pulse_once", 1'b0, 4'b0000, 16'h1234, 2'd1, 1'b0);

        // Asynchronous reset during WRITE aborts with no ack.
        req = 4'b1000; wdata = 64'hBEEF_0000_0000_0000;
        step(); chk_all("rst_pre", 1'b1, 4'b0000, 16'hBEEF, 2'd3, 1'b1);
        req = 4'b0000;
        #2 rst = 1'b1;
        #1 chk_all("rst_async", 1'b0, 4'b0000, 16'h0000, 2'd0, 1'b0);
        step(); step();
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk(.nm($sformatf("rst_noack%0d", i)), .act(64'(ack)), .exp(64'h0));
        end
        req = 4'b1001; wdata = 64'h9999_0000_0000_0101;
        step(); chk_all("rst_prio", 1'b1, 4'b0000, 16'h0101, 2'd0, 1'b1);
        req = 4'b0000;
        step(); step();

        // All requesters busy: drop on ack, re-raise a cycle later.
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1111; wdata = 64'h4444_3333_2222_1111;
        for (int g = 0; g < 8; g++) begin
            step(); chk_all($sformatf("rr%0d_w", g), 1'b1, 4'b0000,
                            16'(16'h1111 * ((g % 4) + 1)), 2'(g % 4), 1'b1);
            step(); chk($sformatf("rr%0d_ack", g), 64'(ack), 64'(4'b1 << (g % 4)));
            req[g % 4] = 1'b0;
            step(); chk($sformatf("rr%0d_idle", g), 64'(busy), 64'h0);
            req[g % 4] = 1'b1;
        end

        // Random traffic against the reference model.
        rst = 1'b1; req = '0; step(); rst = 1'b0;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            req   = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            wdata = {$urandom, $urandom};
            model_edge(req, wdata);
            step();
            chk_all($sformatf("rand%0d", c), m_en, m_ack, m_data, 2'(m_gid), m_busy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
